// File: rtl/multi_node_sched_if.sv
// multi_node_sched_if: control, random and neighbour-routing bundle for multi_node_sched
// master = replica controller / channel side, slave = multi_node_sched.
// Carries seed/sweep requests, status (busy, done, rot), per-channel opt_run and random
// words, raw channel/neighbour data in and routed channel data out.
// sweep_cnt exists only when NODE_SWEEP_CNT_EN is defined.
interface multi_node_sched_if #(
    parameter int CH_NUM = 2,
    parameter int DIS_W  = 32,
    parameter int ORD_W  = 8
);
    localparam int RW = $clog2(CH_NUM);
    logic                    random_init;
    logic [63:0]             random_seed;
    logic                    start;
    logic [15:0]             sweep_len;
    logic                    busy;
    logic                    done;
    logic [RW-1:0]           rot;
    logic [CH_NUM-1:0]       ch_opt_run;
    logic [CH_NUM*32-1:0]    ch_rand;
    logic [CH_NUM*DIS_W-1:0] ch_dis_in;
    logic [CH_NUM-1:0]       ch_ord_valid_in;
    logic [CH_NUM*ORD_W-1:0] ch_ord_in;
    logic [CH_NUM*DIS_W-1:0] prev_dis_in;
    logic [CH_NUM*DIS_W-1:0] folw_dis_in;
    logic [CH_NUM*DIS_W-1:0] ch_prev_dis;
    logic [CH_NUM*DIS_W-1:0] ch_self_dis;
    logic [CH_NUM*DIS_W-1:0] ch_folw_dis;
    logic [CH_NUM-1:0]       ch_ord_valid;
    logic [CH_NUM*ORD_W-1:0] ch_ord;
`ifdef NODE_SWEEP_CNT_EN
    logic [31:0]             sweep_cnt;
`endif
    modport master (
`ifdef NODE_SWEEP_CNT_EN
        input  sweep_cnt,
`endif
        output random_init, random_seed, start, sweep_len,
        output ch_dis_in, ch_ord_valid_in, ch_ord_in, prev_dis_in, folw_dis_in,
        input  busy, done, rot, ch_opt_run, ch_rand,
        input  ch_prev_dis, ch_self_dis, ch_folw_dis, ch_ord_valid, ch_ord
    );
    modport slave (
`ifdef NODE_SWEEP_CNT_EN
        output sweep_cnt,
`endif
        input  random_init, random_seed, start, sweep_len,
        input  ch_dis_in, ch_ord_valid_in, ch_ord_in, prev_dis_in, folw_dis_in,
        output busy, done, rot, ch_opt_run, ch_rand,
        output ch_prev_dis, ch_self_dis, ch_folw_dis, ch_ord_valid, ch_ord
    );
endinterface

// File: rtl/multi_node_sched.sv
// multi_node_sched: N-channel opt-sweep sequencer with per-channel xorshift64 and rotating routing
// Ports: clk, reset (sync, active-high), bus (multi_node_sched_if.slave).
// FSM IDLE -> SEED (one cycle per channel) -> IDLE, IDLE -> RUN (sweep_len cycles) -> EXCH -> IDLE.
// Channel k receives data from channel (k+1+rot) mod CH_NUM; rot advances once per sweep.
// Optional: NODE_SWEEP_CNT_EN adds a saturating completed-sweep counter (bus.sweep_cnt).
module multi_node_sched #(
    parameter int ID          = 0,
    parameter int REPLICA_NUM = 32,
    parameter int CH_NUM      = 2,
    parameter int DIS_W       = 32,
    parameter int ORD_W       = 8
) (
    input logic               clk,
    input logic               reset,
    multi_node_sched_if.slave bus
);
    localparam int RW = $clog2(CH_NUM);
    localparam logic [63:0] GOLD = 64'h9E3779B97F4A7C15;
    if (CH_NUM < 2 || ID >= REPLICA_NUM) begin : g_cfg_err
        $error("multi_node_sched: CH_NUM must be >= 2 and ID < REPLICA_NUM");
    end
    typedef enum logic [1:0] {IDLE, SEED, RUN, EXCH} state_t;
    state_t        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [RW-1:0] rot_q, rot_d, idx_q, idx_d;
    logic          done_q, done_d, run_q, run_d;
    logic [63:0]   rng_q [CH_NUM];
    logic [63:0]   rng_d [CH_NUM];
`ifdef NODE_SWEEP_CNT_EN
    logic [31:0]   sweep_cnt_q, sweep_cnt_d;
    assign bus.sweep_cnt = sweep_cnt_q;
`endif
    function automatic logic [63:0] xs64(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 7);
        return y ^ (y << 17);
    endfunction
    always_comb begin
        logic [63:0] v;
        v       = '0;
        state_d = state_q;
        cnt_d   = cnt_q;
        rot_d   = rot_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        run_d   = 1'b0;
        rng_d   = rng_q;
`ifdef NODE_SWEEP_CNT_EN
        sweep_cnt_d = sweep_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.random_init) begin
                    state_d = SEED;
                    idx_d   = '0;
                end else if (bus.start) begin
                    cnt_d   = bus.sweep_len;
                    state_d = (bus.sweep_len == 16'd0) ? EXCH : RUN;
                    run_d   = bus.sweep_len != 16'd0;
                    done_d  = bus.sweep_len == 16'd0;
                end
            end
            SEED: begin
                // per-channel multiples of GOLD are constants, no runtime multiplier
                for (int k = 0; k < CH_NUM; k++) begin
                    if (int'(idx_q) == k) begin
                        v        = bus.random_seed ^ (64'(k) * GOLD);
                        rng_d[k] = (v == 64'd0) ? 64'd1 : v;
                    end
                end
                idx_d   = idx_q + 1'b1;
                state_d = (int'(idx_q) == CH_NUM - 1) ? IDLE : SEED;
            end
            RUN: begin
                for (int k = 0; k < CH_NUM; k++) rng_d[k] = xs64(rng_q[k]);
                cnt_d   = cnt_q - 16'd1;
                state_d = (cnt_q == 16'd1) ? EXCH : RUN;
                done_d  = cnt_q == 16'd1;
                run_d   = cnt_q != 16'd1;
            end
            default: begin
                rot_d   = (int'(rot_q) == CH_NUM - 1) ? '0 : rot_q + 1'b1;
                state_d = IDLE;
`ifdef NODE_SWEEP_CNT_EN
                sweep_cnt_d = (sweep_cnt_q == 32'hFFFF_FFFF) ? sweep_cnt_q : sweep_cnt_q + 32'd1;
`endif
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rot_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
            for (int k = 0; k < CH_NUM; k++) rng_q[k] <= 64'(k + 1);
`ifdef NODE_SWEEP_CNT_EN
            sweep_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rot_q   <= rot_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            run_q   <= run_d;
            rng_q   <= rng_d;
`ifdef NODE_SWEEP_CNT_EN
            sweep_cnt_q <= sweep_cnt_d;
`endif
        end
    end
    assign bus.busy       = state_q != IDLE;
    assign bus.done       = done_q;
    assign bus.rot        = rot_q;
    assign bus.ch_opt_run = {CH_NUM{run_q}};
    // k+1+rot never exceeds 2*CH_NUM-1, so one conditional subtract implements the wrap
    always_comb begin
        int s;
        s                = 0;
        bus.ch_rand      = '0;
        bus.ch_self_dis  = '0;
        bus.ch_prev_dis  = '0;
        bus.ch_folw_dis  = '0;
        bus.ch_ord_valid = '0;
        bus.ch_ord       = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            s = k + 1 + int'(rot_q);
            s = (s >= CH_NUM) ? s - CH_NUM : s;
            bus.ch_rand[k*32 +: 32]        = rng_q[k][31:0];
            bus.ch_self_dis[k*DIS_W +: DIS_W] = bus.ch_dis_in[s*DIS_W +: DIS_W];
            bus.ch_prev_dis[k*DIS_W +: DIS_W] = bus.prev_dis_in[s*DIS_W +: DIS_W];
            bus.ch_folw_dis[k*DIS_W +: DIS_W] = bus.folw_dis_in[s*DIS_W +: DIS_W];
            bus.ch_ord_valid[k]            = bus.ch_ord_valid_in[s];
            bus.ch_ord[k*ORD_W +: ORD_W]   = bus.ch_ord_in[s*ORD_W +: ORD_W];
        end
    end
endmodule

// File: tb/tb_multi_node_sched.sv
// tb_multi_node_sched: directed + randomized checks of multi_node_sched (CH_NUM=3) against a sweep-level model
module tb_multi_node_sched;
    localparam int CH = 3, DW = 32, OW = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0, passed = 0, failed = 0;
    logic [63:0] mr [CH];
    int mrot = 0, msweep = 0;
    multi_node_sched_if #(.CH_NUM(CH), .DIS_W(DW), .ORD_W(OW)) bus ();
    multi_node_sched #(.ID(0), .REPLICA_NUM(32), .CH_NUM(CH), .DIS_W(DW), .ORD_W(OW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    always #5 clk = ~clk;
    function automatic logic [63:0] xorshift(input logic [63:0] x);
        x ^= x << 13;
        x ^= x >> 7;
        x ^= x << 17;
        return x;
    endfunction
    function automatic logic [63:0] seed_of(input logic [63:0] s, input int k);
        logic [63:0] v;
        v = s ^ (64'(k) * 64'h9E3779B97F4A7C15);
        return (v == 64'd0) ? 64'd1 : v;
    endfunction
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic rand_inputs();
        for (int k = 0; k < CH; k++) begin
            bus.ch_dis_in[k*DW +: DW]   = $urandom;
            bus.prev_dis_in[k*DW +: DW] = $urandom;
            bus.folw_dis_in[k*DW +: DW] = $urandom;
            bus.ch_ord_in[k*OW +: OW]   = OW'($urandom);
        end
        bus.ch_ord_valid_in = CH'($urandom);
        #1;
    endtask
    task automatic chk_route();
        for (int k = 0; k < CH; k++) begin
            int s;
            s = (k + 1 + mrot) % CH;
            chk("self_dis", 64'(bus.ch_self_dis[k*DW +: DW]), 64'(bus.ch_dis_in[s*DW +: DW]));
            chk("prev_dis", 64'(bus.ch_prev_dis[k*DW +: DW]), 64'(bus.prev_dis_in[s*DW +: DW]));
            chk("folw_dis", 64'(bus.ch_folw_dis[k*DW +: DW]), 64'(bus.folw_dis_in[s*DW +: DW]));
            chk("ord_valid", 64'(bus.ch_ord_valid[k]), 64'(bus.ch_ord_valid_in[s]));
            chk("ord", 64'(bus.ch_ord[k*OW +: OW]), 64'(bus.ch_ord_in[s*OW +: OW]));
        end
    endtask
    task automatic chk_state(input bit run, input bit dn, input bit bsy);
        chk("opt_run", 64'(bus.ch_opt_run), 64'({CH{run}}));
        chk("done", 64'(bus.done), 64'(dn));
        chk("busy", 64'(bus.busy), 64'(bsy));
        chk("rot", 64'(bus.rot), 64'(mrot));
        for (int k = 0; k < CH; k++) chk("ch_rand", 64'(bus.ch_rand[k*32 +: 32]), 64'(mr[k][31:0]));
`ifdef NODE_SWEEP_CNT_EN
        chk("sweep_cnt", 64'(bus.sweep_cnt), 64'(msweep));
`endif
    endtask
    task automatic model_reset();
        for (int k = 0; k < CH; k++) mr[k] = 64'(k + 1);
        mrot   = 0;
        msweep = 0;
    endtask
    task automatic do_seed(input logic [63:0] s, input bit with_start);
        bus.random_seed = s;
        bus.random_init = 1'b1;
        bus.start       = with_start;
        bus.sweep_len   = 16'd4;
        step();
        bus.random_init = 1'b0;
        bus.start       = 1'b0;
        for (int i = 0; i < CH; i++) begin
            chk_state(0, 0, 1);
            step();
            mr[i] = seed_of(s, i);
        end
        chk_state(0, 0, 0);
    endtask
    task automatic sweep(input int len, input bit poke);
        bus.sweep_len = 16'(len);
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 1; i <= len; i++) begin
            bus.start       = poke && i == 2;
            bus.random_init = poke && i == 2;
            rand_inputs();
            chk_route();
            chk_state(1, 0, 1);
            for (int k = 0; k < CH; k++) mr[k] = xorshift(mr[k]);
            step();
        end
        bus.start       = 1'b0;
        bus.random_init = 1'b0;
        rand_inputs();
        chk_route();
        chk_state(0, 1, 1);
        step();
        mrot = (mrot + 1) % CH;
        msweep++;
        chk_state(0, 0, 0);
        chk_route();
    endtask
    initial begin
        bus.random_init = 1'b0;
        bus.random_seed = '0;
        bus.start       = 1'b0;
        bus.sweep_len   = '0;
        rand_inputs();
        model_reset();
        step();
        step();
        chk_state(0, 0, 0);
        reset = 1'b0;
        step();
        chk_state(0, 0, 0);
        chk_route();
        do_seed(64'h0, 1'b0);
        chk("seed0_rand0", 64'(bus.ch_rand[31:0]), 64'h1);
        chk("seed0_rand1", 64'(bus.ch_rand[63:32]), 64'h7F4A7C15);
        sweep(3, 1'b0);
        sweep(0, 1'b0);
        sweep($urandom_range(2, 8), 1'b1);
        sweep($urandom_range(1, 8), 1'b0);
        do_seed({$urandom, $urandom}, 1'b1);
        for (int n = 0; n < 4; n++) sweep($urandom_range(0, 9), n[0]);
        bus.sweep_len = 16'd5;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        chk_state(1, 0, 1);
        for (int k = 0; k < CH; k++) mr[k] = xorshift(mr[k]);
        step();
        chk_state(1, 0, 1);
        reset = 1'b1;
        step();
        model_reset();
        chk_state(0, 0, 0);
        reset = 1'b0;
        step();
        chk_state(0, 0, 0);
        sweep(2, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
